// File: rtl/jpeg_rld_if.sv
// jpeg_rld_if: token input and coefficient output bundle of the run-length decoder
interface jpeg_rld_if #(parameter int AW = 12);
   logic          ena;
   logic [3:0]    rleni;
   logic [3:0]    sizei;
   logic [AW-1:0] ampi;
   logic          deni;
   logic          dci;
   logic          din_rdy;
   logic [AW-1:0] dout;
   logic          douten;
   logic          dstrb;
   logic [5:0]    dcnt;
   logic          bdone;
   logic          err;
   modport master (output ena, rleni, sizei, ampi, deni, dci,
                   input din_rdy, dout, douten, dstrb, dcnt, bdone, err);
   modport slave  (input ena, rleni, sizei, ampi, deni, dci,
                   output din_rdy, dout, douten, dstrb, dcnt, bdone, err);
endinterface

// File: rtl/jpeg_rld.sv
// jpeg_rld: expands (rlen, size, amp) tokens into 64 zigzag-ordered coefficients per block
module jpeg_rld #(parameter int AW = 12) (
   input logic clk,
   input logic rst,
   jpeg_rld_if.slave bus
);
   typedef enum logic [2:0] {IDLE, AC, RUN, AMP, FILL} state_t;
   state_t        state, state_n, after;
   logic [5:0]    cnt;
   logic [3:0]    zr, zr_n;
   logic [AW-1:0] amp, amp_n, val;
   logic          zrl, zrl_n, emit, more, e, strb, last, acc, zs;
   assign zs = bus.sizei == 4'd0;
   // a DC token arriving mid-block is refused so it can open the next block from IDLE
   assign bus.din_rdy = bus.ena & (state == IDLE | (state == AC & ~(bus.deni & bus.dci)));
   always_comb begin
      acc = bus.deni & bus.din_rdy;
      after = state;
      zr_n = zr;
      amp_n = amp;
      zrl_n = zrl;
      emit = 1'b0;
      val = '0;
      more = 1'b0;
      e = 1'b0;
      strb = 1'b0;
      case (state)
         IDLE: begin
            emit = acc & bus.dci;
            strb = emit;
            val = emit ? bus.ampi : '0;
            after = emit ? AC : IDLE;
            e = acc & ~bus.dci & (bus.rleni != 4'd0 | ~zs);
         end
         AC: begin
            // the first coefficient of every token is produced in its acceptance cycle
            emit = acc;
            e = (bus.deni & bus.dci) | (acc & zs & bus.rleni != 4'd0 & bus.rleni != 4'd15);
            val = acc & ~zs & bus.rleni == 4'd0 ? bus.ampi : '0;
            more = zs ? bus.rleni == 4'd15 : bus.rleni != 4'd0;
            if (acc) begin
               amp_n = bus.ampi;
               zrl_n = zs;
               zr_n = zs ? 4'd15 : bus.rleni - 4'd1;
            end
            after = bus.deni & bus.dci ? FILL :
                    ~acc ? AC :
                    zs ? (bus.rleni == 4'd15 ? RUN : FILL) :
                    bus.rleni == 4'd0 ? AC :
                    bus.rleni == 4'd1 ? AMP : RUN;
         end
         RUN: begin
            emit = 1'b1;
            zr_n = zr - 4'd1;
            more = ~(zrl & zr == 4'd1);
            after = zr == 4'd1 ? (zrl ? AC : AMP) : RUN;
         end
         AMP: begin
            emit = 1'b1;
            val = amp;
            after = AC;
         end
         default: emit = 1'b1;
      endcase
      last = emit & cnt == 6'd63;
      state_n = last ? IDLE : after;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         zr <= '0;
         amp <= '0;
         zrl <= 1'b0;
         bus.dout <= '0;
         bus.douten <= 1'b0;
         bus.dstrb <= 1'b0;
         bus.dcnt <= '0;
         bus.bdone <= 1'b0;
         bus.err <= 1'b0;
      end else if (bus.ena) begin
         state <= state_n;
         cnt <= emit ? cnt + 6'd1 : cnt;
         zr <= zr_n;
         amp <= amp_n;
         zrl <= zrl_n;
         bus.dout <= val;
         bus.douten <= emit;
         bus.dstrb <= strb;
         bus.dcnt <= emit ? cnt : bus.dcnt;
         bus.bdone <= last;
         bus.err <= e | (last & more);
      end
   end
endmodule

// File: tb/tb_jpeg_rld.sv
// tb_jpeg_rld: directed token streams with hand-computed coefficient expectations
module tb_jpeg_rld;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   jpeg_rld_if #(.AW(12)) bus ();
   jpeg_rld #(.AW(12)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0, errors = 0;
   int nout = 0, errs = 0, cyc = 0, base = 0, e0 = 0, nacc = 0;
   logic [11:0] v [1024];
   logic [5:0]  ix [1024];
   bit          st [1024], bd [1024], er [1024];
   int          cy [1024];
   longint      acc_t [128];
   always @(negedge clk) begin
      cyc++;
      if (bus.ena) begin
         if (bus.err) errs++;
         if (bus.douten && nout < 1024) begin
            v[nout] = bus.dout;
            ix[nout] = bus.dcnt;
            st[nout] = bus.dstrb;
            bd[nout] = bus.bdone;
            er[nout] = bus.err;
            cy[nout] = cyc;
            nout++;
         end
      end
   end
   task automatic check(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic send(logic dc, logic [3:0] r, logic [3:0] s, logic [11:0] a);
      bit ok;
      int n;
      bus.dci = dc;
      bus.rleni = r;
      bus.sizei = s;
      bus.ampi = a;
      bus.deni = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         ok = bus.din_rdy;
         if (ok && nacc < 128) acc_t[nacc++] = $time;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 300);
      if (!ok) check("send_timeout", 0, 1);
   endtask
   task automatic idle();
      bus.deni = 1'b0;
      bus.dci = 1'b0;
      bus.rleni = '0;
      bus.sizei = '0;
      bus.ampi = '0;
   endtask
   task automatic start();
      base = nout;
      e0 = errs;
      nacc = 0;
   endtask
   task automatic wait_out(int n);
      int k = 0;
      while (nout < base + n && k < 400) begin
         @(posedge clk);
         k++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask
   function automatic int nz(int lo, int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (v[base+i] != 0) c++;
      return c;
   endfunction
   function automatic int nbd(int lo, int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (bd[base+i]) c++;
      return c;
   endfunction
   initial begin
      bus.ena = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_douten", bus.douten, 0);
      check("rst_dout", bus.dout, 0);
      check("rst_dcnt", bus.dcnt, 0);
      check("rst_bdone", bus.bdone, 0);
      check("rst_err", bus.err, 0);
      check("rst_rdy", bus.din_rdy, 1);
      // DC then EOB
      start();
      send(1, 0, 0, 12'h123);
      send(0, 0, 0, 0);
      idle();
      wait_out(64);
      check("t1_count", nout - base, 64);
      check("t1_dc", v[base], 'h123);
      check("t1_strb", st[base], 1);
      check("t1_zeros", nz(1, 63), 0);
      check("t1_bdone_pos", bd[base+63], 1);
      check("t1_bdone_cnt", nbd(0, 63), 1);
      check("t1_idx63", ix[base+63], 63);
      check("t1_err", errs - e0, 0);
      // run of two then amp, direct amp, EOB
      start();
      send(1, 0, 0, 12'd5);
      send(0, 2, 3, 12'hFFD);
      send(0, 0, 1, 12'd1);
      send(0, 0, 0, 0);
      idle();
      wait_out(64);
      check("t2_count", nout - base, 64);
      check("t2_c0", v[base], 5);
      check("t2_c12", nz(1, 2), 0);
      check("t2_c3", v[base+3], 'hFFD);
      check("t2_c4", v[base+4], 1);
      check("t2_tail", nz(5, 63), 0);
      check("t2_continuous", cy[base+63] - cy[base], 63);
      check("t2_err", errs - e0, 0);
      // two ZRLs then (1,2,2)
      start();
      send(1, 0, 0, 12'd0);
      send(0, 15, 0, 0);
      send(0, 15, 0, 0);
      send(0, 1, 2, 12'd2);
      send(0, 0, 0, 0);
      idle();
      wait_out(64);
      check("t3_count", nout - base, 64);
      check("t3_c34", v[base+34], 2);
      check("t3_nonzero", nz(0, 63), 1);
      check("t3_zrl1_gap", int'((acc_t[2] - acc_t[1]) / 10), 16);
      check("t3_zrl2_gap", int'((acc_t[3] - acc_t[2]) / 10), 16);
      check("t3_err", errs - e0, 0);
      // 64-token block and trailing EOB
      start();
      send(1, 0, 0, 12'd0);
      for (int i = 1; i < 64; i++) send(0, 0, 6, 12'(i));
      send(0, 0, 0, 0);
      idle();
      wait_out(64);
      begin
         int bad = 0;
         for (int i = 0; i < 64; i++) if (v[base+i] != 12'(i) || ix[base+i] != 6'(i)) bad++;
         check("t4_seq", bad, 0);
      end
      check("t4_count", nout - base, 64);
      check("t4_bdone", bd[base+63], 1);
      check("t4_err", errs - e0, 0);
      // premature DC after 10 coefficients
      start();
      send(1, 0, 0, 12'd1);
      for (int i = 1; i < 10; i++) send(0, 0, 4, 12'(i));
      send(1, 0, 0, 12'h55);
      send(0, 0, 0, 0);
      idle();
      wait_out(128);
      check("t5_count", nout - base, 128);
      check("t5_c9", v[base+9], 9);
      check("t5_fill", nz(10, 63), 0);
      check("t5_bdone", bd[base+63], 1);
      check("t5_err", errs - e0, 1);
      check("t5_newdc", v[base+64], 'h55);
      check("t5_newstrb", st[base+64], 1);
      check("t5_newdc_next", cy[base+64] - cy[base+63], 1);
      // overflow truncation at index 63
      start();
      send(1, 0, 0, 12'd0);
      for (int i = 1; i < 30; i++) send(0, 0, 2, 12'h100 + 12'(i));
      send(0, 15, 0, 0);
      send(0, 15, 0, 0);
      send(0, 15, 1, 12'd7);
      idle();
      wait_out(64);
      check("t6_count", nout - base, 64);
      check("t6_zeros", nz(30, 63), 0);
      check("t6_bdone", bd[base+63], 1);
      check("t6_err_on_bdone", er[base+63], 1);
      check("t6_err", errs - e0, 1);
      check("t6_rdy_idle", bus.din_rdy, 1);
      // ena freeze mid-RUN
      start();
      send(1, 0, 0, 12'h11);
      send(0, 15, 1, 12'd9);
      idle();
      repeat (2) @(posedge clk);
      #1;
      bus.ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ena_dcnt", bus.dcnt, 3);
      check("ena_dout", bus.dout, 0);
      check("ena_douten", bus.douten, 1);
      check("ena_rdy", bus.din_rdy, 0);
      bus.ena = 1'b1;
      @(posedge clk);
      #1;
      check("ena_resume", bus.dcnt, 4);
      send(0, 0, 0, 0);
      idle();
      wait_out(64);
      check("ena_count", nout - base, 64);
      check("ena_c16", v[base+16], 9);
      check("ena_err", errs - e0, 0);
      // reset mid-RUN
      start();
      send(1, 0, 0, 12'h22);
      send(0, 15, 1, 12'd3);
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst_douten", bus.douten, 0);
      check("mrst_dcnt", bus.dcnt, 0);
      check("mrst_rdy", bus.din_rdy, 1);
      repeat (6) @(posedge clk);
      #1;
      check("mrst_count", nout - base, 4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
